mux_nway_reg: RTL and testbench
===============================

Name: mux_nway_reg

Overview:
- Parametrised successor to the datapath 2:1 word mux.
- Selects one of NUM_IN data channels, each with its own valid/ready handshake.
- Registers the winner into a single output stage with a valid/ready handshake.
- MODE chooses between explicit select (forwarding/writeback paths) and round-robin arbitration (shared-resource paths such as a memory port).

Parameters:
- WIDTH, 32, data word width in bits.
- NUM_IN, 4, number of input channels; legal range 2..16.
- MODE, 0, 0 = explicit select via Sel; 1 = round-robin among valid inputs.
- SEL_W, $clog2(NUM_IN), select/index width; derived, never overridden.

Ports:
- Clk  in  1  rising-edge clock.
- Rst  in  1  synchronous active-high reset.
- InData  in  NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- InValid  in  NUM_IN  per-channel valid.
- InReady  out  NUM_IN  per-channel ready; combinational.
- Sel  in  SEL_W  channel select; used only when MODE=0.
- OutData  out  WIDTH  registered selected word.
- OutValid  out  1  OutData holds an unconsumed word.
- OutReady  in  1  downstream accepts the word.
- OutSrc  out  SEL_W  index of the channel that produced OutData.

Behaviour:
- Clocking and reset:
  - Single clock Clk.
  - Rst is synchronous and active-high.
  - On Rst: OutValid=0, OutData=0, OutSrc=0, round-robin pointer Ptr=0. Rst overrides any transfer in the same cycle.
  - Rst asserted mid-stream discards the held word. No InReady is asserted while Rst=1.
- Load enable:
  - load_en = !OutValid || OutReady.
  - This is a pass-through-ready single stage: full throughput, one word per cycle, no skid buffer.
- Grant, MODE=0:
  - grant = one-hot(Sel) & InValid.
  - Sel >= NUM_IN gives no grant and accepts nothing.
- Grant, MODE=1:
  - grant = first valid channel scanning Ptr, Ptr+1, …, NUM_IN-1, 0, …, Ptr-1 (wrap-around).
  - No valid channel gives no grant.
- Ready and transfer:
  - InReady[i] = grant[i] && load_en && !Rst. At most one InReady is high per cycle.
  - An input transfer occurs on channel i when InValid[i] && InReady[i].
- Output register update at the clock edge:
  - Input transfer on channel g: OutData <= channel g data, OutSrc <= g, OutValid <= 1.
  - Otherwise, if OutReady && OutValid: OutValid <= 0. OutData and OutSrc hold their last values.
  - Simultaneous output consume and input accept in one cycle: the new word replaces the old one and OutValid stays 1.
- Latency: 1 cycle from an accepted input to OutValid.
- Pointer:
  - Ptr updates only on an input transfer: Ptr <= g+1, or 0 when g = NUM_IN-1.
  - MODE=0 never updates Ptr.
- Stability: while OutValid=1 and OutReady=0, OutData and OutSrc are held stable.
- Inputs: InValid may drop without a handshake. The block assumes no input-side stability rule.

Decomposition:
- Shared package entry: the MODE encodings, MUX_MODE_SEL=0 and MUX_MODE_RR=1.
- One natural sub-module, rr_grant:
  - Purely combinational.
  - Inputs: NUM_IN valid vector, SEL_W pointer.
  - Outputs: one-hot grant and encoded index.
  - Implemented as a double-width vector scan.
- Output register, ready generation and pointer update stay in mux_nway_reg.

Test Plan:
1. Reset and idle: Rst=1 for 2 cycles with InValid=4'b1111 -> OutValid=0, OutData=0, InReady=0. After release with OutReady=1, OutValid=1 on the next edge.
2. MODE=0 select: Sel=2, InValid=4'b0100, ch2=32'hDEADBEEF, OutReady=1 -> one cycle later OutData=32'hDEADBEEF, OutSrc=2. Sel=3 with InValid=4'b0100 -> InReady=0, no transfer.
3. Backpressure: OutValid=1, OutReady=0 for 5 cycles with ch1 valid -> InReady=0 and OutData held. OutReady=1 -> the same cycle accepts ch1 and OutValid stays 1.
4. MODE=1 fairness: all 4 channels valid continuously, OutReady=1 -> OutSrc sequence 0,1,2,3,0,1 at full throughput.
5. MODE=1 wrap and skip: Ptr=3, InValid=4'b0011 -> grant ch0, Ptr becomes 1. Next cycle grant ch1, Ptr becomes 2.
6. Reset mid-stream: OutValid=1 holding 32'h12345678, Rst=1 for 1 cycle -> OutValid=0, OutData=0, Ptr=0, no InReady during reset.

Source files
------------

// File: rtl/mux_nway_reg_pkg.sv
// rtl/mux_nway_reg_pkg.sv - shared mode encodings and index helper for the n-way registered mux
package mux_nway_reg_pkg;

    localparam int MUX_MODE_SEL = 0;
    localparam int MUX_MODE_RR  = 1;

    // Next round-robin start position: one past the winner, wrapping to 0.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mux_nway_reg_rr_grant.sv
// rtl/mux_nway_reg_rr_grant.sv - combinational round-robin grant from a start pointer
module mux_nway_reg_rr_grant
    import mux_nway_reg_pkg::*;
#(
    parameter int NUM_IN = 4,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0] valid,
    input  logic [SEL_W-1:0]  ptr,
    output logic [NUM_IN-1:0] grant,
    output logic [SEL_W-1:0]  idx
);

    // Rotating the doubled vector right by ptr puts channel ptr at bit 0,
    // so a plain lowest-set-bit scan gives the wrap-around priority order.
    logic [NUM_IN-1:0] scan;
    assign scan = NUM_IN'({valid, valid} >> ptr);

    // Find the first requester at or after ptr and map it back to a channel index.
    always_comb begin
        logic             found;
        logic [SEL_W:0]   pos;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (!found && scan[k]) begin
                found = 1'b1;
                pos   = {1'b0, ptr} + (SEL_W+1)'(k);
                if (pos >= (SEL_W+1)'(NUM_IN)) begin
                    pos = pos - (SEL_W+1)'(NUM_IN);
                end
                idx   = pos[SEL_W-1:0];
                grant = NUM_IN'(1) << pos[SEL_W-1:0];
            end
        end
    end

endmodule

// File: rtl/mux_nway_reg.sv
// rtl/mux_nway_reg.sv - n-way valid/ready mux with explicit-select or round-robin grant and one output register
module mux_nway_reg
    import mux_nway_reg_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int MODE   = MUX_MODE_SEL,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic [NUM_IN*WIDTH-1:0] InData,
    input  logic [NUM_IN-1:0]       InValid,
    output logic [NUM_IN-1:0]       InReady,
    input  logic [SEL_W-1:0]        Sel,
    output logic [WIDTH-1:0]        OutData,
    output logic                    OutValid,
    input  logic                    OutReady,
    output logic [SEL_W-1:0]        OutSrc
);

    logic              load_en;
    logic              xfer;
    logic [SEL_W-1:0]  ptr;
    logic [NUM_IN-1:0] sel_grant;
    logic [NUM_IN-1:0] rr_grant;
    logic [SEL_W-1:0]  rr_idx;
    logic [NUM_IN-1:0] grant;
    logic [SEL_W-1:0]  gidx;

    // The stage can take a word whenever it is empty or is being drained this cycle.
    assign load_en = !OutValid || OutReady;

    mux_nway_reg_rr_grant #(
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_rr_grant (
        .valid (InValid),
        .ptr   (ptr),
        .grant (rr_grant),
        .idx   (rr_idx)
    );

    // Explicit select: an out-of-range Sel matches no channel and grants nothing.
    always_comb begin
        sel_grant = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            sel_grant[i] = (Sel == SEL_W'(i)) && InValid[i];
        end
    end

    // Pick the grant source for this build's mode.
    always_comb begin
        if (MODE == MUX_MODE_RR) begin
            grant = rr_grant;
            gidx  = rr_idx;
        end else begin
            grant = sel_grant;
            gidx  = Sel;
        end
    end

    // Ready is only offered when the stage can load and reset is not active.
    always_comb begin
        InReady = (load_en && !Rst) ? grant : '0;
    end

    assign xfer = |(InReady & InValid);

    // Output register and round-robin pointer; a new word replaces a consumed one without a bubble.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            OutValid <= 1'b0;
            OutData  <= '0;
            OutSrc   <= '0;
            ptr      <= '0;
        end else if (xfer) begin
            OutValid <= 1'b1;
            OutData  <= InData[gidx*WIDTH +: WIDTH];
            OutSrc   <= gidx;
            if (MODE == MUX_MODE_RR) begin
                ptr <= SEL_W'(wrap_inc(int'(gidx), NUM_IN));
            end
        end else if (OutReady && OutValid) begin
            OutValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_nway_reg.sv
// tb/tb_mux_nway_reg.sv - bench for select and round-robin builds of mux_nway_reg
module tb_mux_nway_reg;

    localparam int W = 32;
    localparam int N = 4;

    logic         Clk = 1'b0;
    logic         Rst;
    logic [N*W-1:0] InData;
    logic [N-1:0] InValid;
    logic [1:0]   Sel;
    logic         OutReady;

    logic [N-1:0] s_InReady, r_InReady;
    logic [W-1:0] s_OutData, r_OutData;
    logic         s_OutValid, r_OutValid;
    logic [1:0]   s_OutSrc, r_OutSrc;

    int checks = 0;
    int errors = 0;

    // reference state: index 0 = select build, 1 = round-robin build
    logic         m_valid [2];
    logic [W-1:0] m_data  [2];
    int           m_src   [2];
    int           m_ptr;

    always #5 Clk = ~Clk;

    mux_nway_reg #(.WIDTH(W), .NUM_IN(N), .MODE(0)) u_sel (
        .Clk(Clk), .Rst(Rst), .InData(InData), .InValid(InValid), .InReady(s_InReady),
        .Sel(Sel), .OutData(s_OutData), .OutValid(s_OutValid), .OutReady(OutReady), .OutSrc(s_OutSrc)
    );

    mux_nway_reg #(.WIDTH(W), .NUM_IN(N), .MODE(1)) u_rr (
        .Clk(Clk), .Rst(Rst), .InData(InData), .InValid(InValid), .InReady(r_InReady),
        .Sel(Sel), .OutData(r_OutData), .OutValid(r_OutValid), .OutReady(OutReady), .OutSrc(r_OutSrc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] chan(input int c);
        return InData[c*W +: W];
    endfunction

    // winning channel for each build, -1 when nothing may be accepted
    function automatic int win(input int b);
        if (Rst || (m_valid[b] && !OutReady)) return -1;
        if (b == 0) begin
            if (int'(Sel) < N && InValid[Sel]) return int'(Sel);
            return -1;
        end
        for (int k = 0; k < N; k++) begin
            if (InValid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic step();
        int g [2];
        #1;
        g[0] = win(0);
        g[1] = win(1);
        chk("s_inready", 32'(s_InReady), (g[0] < 0) ? 32'd0 : (32'd1 << g[0]));
        chk("r_inready", 32'(r_InReady), (g[1] < 0) ? 32'd0 : (32'd1 << g[1]));
        @(posedge Clk);
        #1;
        for (int b = 0; b < 2; b++) begin
            if (Rst) begin
                m_valid[b] = 1'b0; m_data[b] = '0; m_src[b] = 0;
                if (b == 1) m_ptr = 0;
            end else if (g[b] >= 0) begin
                m_valid[b] = 1'b1; m_data[b] = chan(g[b]); m_src[b] = g[b];
                if (b == 1) m_ptr = (g[b] + 1) % N;
            end else if (OutReady) begin
                m_valid[b] = 1'b0;
            end
        end
        chk("s_outvalid", 32'(s_OutValid), 32'(m_valid[0]));
        chk("s_outdata",  s_OutData, m_data[0]);
        chk("s_outsrc",   32'(s_OutSrc), 32'(m_src[0]));
        chk("r_outvalid", 32'(r_OutValid), 32'(m_valid[1]));
        chk("r_outdata",  r_OutData, m_data[1]);
        chk("r_outsrc",   32'(r_OutSrc), 32'(m_src[1]));
    endtask

    initial begin
        for (int b = 0; b < 2; b++) begin
            m_valid[b] = 1'b0; m_data[b] = '0; m_src[b] = 0;
        end
        m_ptr = 0;

        // reset and idle
        Rst = 1'b1; InValid = 4'b1111; OutReady = 1'b1; Sel = 2'd0;
        InData = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
        step();
        step();
        chk("rst_inready", 32'(s_InReady | r_InReady), 32'd0);
        Rst = 1'b0;
        step();
        chk("rel_outvalid", 32'(s_OutValid), 32'd1);

        // explicit select
        Sel = 2'd2; InValid = 4'b0100; InData[2*W +: W] = 32'hDEADBEEF;
        step();
        chk("sel2_data", s_OutData, 32'hDEADBEEF);
        chk("sel2_src", 32'(s_OutSrc), 32'd2);
        Sel = 2'd3;
        step();
        chk("sel3_noxfer", 32'(s_OutValid), 32'd0);

        // backpressure
        Sel = 2'd1; InValid = 4'b0010; InData[W +: W] = 32'hA5A5A5A5;
        step();
        OutReady = 1'b0; InData[W +: W] = 32'h5A5A5A5A;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_ready", 32'(s_InReady), 32'd0);
            chk("bp_hold", s_OutData, 32'hA5A5A5A5);
        end
        OutReady = 1'b1;
        step();
        chk("bp_accept", s_OutData, 32'h5A5A5A5A);
        chk("bp_valid", 32'(s_OutValid), 32'd1);

        // round-robin fairness at full throughput
        Rst = 1'b1; step(); Rst = 1'b0;
        InValid = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rr_seq", 32'(r_OutSrc), 32'(i % 4));
        end

        // wrap and skip
        Rst = 1'b1; step(); Rst = 1'b0;
        InValid = 4'b0100; step();
        InValid = 4'b0011; step();
        chk("wrap_ch0", 32'(r_OutSrc), 32'd0);
        step();
        chk("wrap_ch1", 32'(r_OutSrc), 32'd1);

        // reset mid-stream
        Sel = 2'd0; InValid = 4'b0001; InData[0 +: W] = 32'h12345678;
        step();
        OutReady = 1'b0; InValid = 4'b0000;
        step();
        chk("mid_held", s_OutData, 32'h12345678);
        Rst = 1'b1; InValid = 4'b1111;
        step();
        chk("mid_valid", 32'(s_OutValid | r_OutValid), 32'd0);
        chk("mid_data", s_OutData, 32'd0);
        Rst = 1'b0; OutReady = 1'b1;
        step();
        chk("mid_ptr0", 32'(r_OutSrc), 32'd0);

        // randomized traffic against the reference
        for (int i = 0; i < 400; i++) begin
            InData   = {$urandom, $urandom, $urandom, $urandom};
            InValid  = 4'($urandom);
            Sel      = 2'($urandom);
            OutReady = ($urandom_range(0, 3) != 0);
            Rst      = ($urandom_range(0, 31) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
